// File: rtl/repeat_seq_checker_pkg.sv
// Shared types and helpers for the repeat_seq_checker slice: FSM state
// encoding, run-counter and error-counter widths, and the wrap-around
// successor function used to predict the next counter value.
package repeat_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

  localparam int RC_W = 4;
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Successor of v in a counter that wraps to 0 after maxv. The caller
  // truncates the result to its own data width.
  function automatic int unsigned nxt_wrap(input int unsigned v, input int unsigned maxv);
    return (v == maxv) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/repeat_seq_checker_run_len_cnt.sv
// Run-length counter for repeat_seq_checker: counts how many consecutive
// samples of the current value have been seen and compares against REP.
module seq_run_len_cnt
  import repeat_seq_checker_pkg::*;
#(
  parameter int REP = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  output logic [RC_W-1:0] rc,
  output logic            at_rep,
  output logic            below_rep
);

  logic [RC_W-1:0] rc_q;
  logic [RC_W-1:0] rc_d;

  // Next count: a new run restarts at 1, a repeated sample adds one.
  always_comb begin
    rc_d = rc_q;
    if (load) begin
      rc_d = RC_W'(1);
    end else if (inc) begin
      rc_d = rc_q + RC_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q <= '0;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc        = rc_q;
  assign at_rep    = (rc_q == RC_W'(REP));
  assign below_rep = (rc_q <  RC_W'(REP));

endmodule

// File: rtl/repeat_seq_checker.sv
// repeat_seq_checker: monitors a repeated-value sequence counter (each value
// REP times, counting up, wrapping after MAXV). Locks onto the run phase,
// flags run-length and ordering violations, and strobes each new value.
// Optional feature macro: CHK_CLR_EN adds the err_clr input, which clears
// the sticky error flag and error count without disturbing tracking.
module repeat_seq_checker
  import repeat_seq_checker_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP   = 5,
  parameter int MAXV  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     din,
  output logic                 locked,
  output logic [WIDTH-1:0]     cur_val,
  output logic                 new_val,
  output logic                 err_pulse,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef CHK_CLR_EN
  ,
  input  logic                 err_clr
`endif
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       cur_val_q, cur_val_d;
  logic                   locked_q, locked_d;
  logic                   new_val_q, new_val_d;
  logic                   err_pulse_q, err_pulse_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   rc_load, rc_inc;
  logic [RC_W-1:0]        rc;
  logic                   rc_at_rep, rc_below_rep;
  logic                   viol;
  logic                   clr_req;
  logic [WIDTH-1:0]       nxt_cur;
  logic                   din_in_range;

`ifdef CHK_CLR_EN
  assign clr_req = err_clr;
`else
  assign clr_req = 1'b0;
`endif

  assign nxt_cur      = WIDTH'(nxt_wrap(32'(cur_val_q), MAXV));
  assign din_in_range = (32'(din) <= MAXV);

  seq_run_len_cnt #(
    .REP (REP)
  ) u_run_len_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (rc_load),
    .inc       (rc_inc),
    .rc        (rc),
    .at_rep    (rc_at_rep),
    .below_rep (rc_below_rep)
  );

  // Phase-lock FSM: next state, current value, run counter control, strobes.
  always_comb begin
    state_d     = state_q;
    cur_val_d   = cur_val_q;
    rc_load     = 1'b0;
    rc_inc      = 1'b0;
    new_val_d   = 1'b0;
    err_pulse_d = 1'b0;
    viol        = 1'b0;
    if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          cur_val_d = din;
          rc_load   = 1'b1;
          state_d   = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          // Run phase unknown: a value step is the first trustworthy edge.
          if (din == cur_val_q) begin
            state_d = ST_ACQUIRE;
          end else if (din == nxt_cur) begin
            cur_val_d = din;
            rc_load   = 1'b1;
            new_val_d = 1'b1;
            state_d   = ST_TRACK;
          end else begin
            cur_val_d = din;
          end
        end
        ST_TRACK: begin
          // Out-of-range values are never legal here, even if they alias.
          if (din_in_range && din == cur_val_q && rc_below_rep) begin
            rc_inc = 1'b1;
          end else if (din_in_range && din == nxt_cur && rc_at_rep) begin
            cur_val_d = din;
            rc_load   = 1'b1;
            new_val_d = 1'b1;
          end else begin
            viol        = 1'b1;
            err_pulse_d = 1'b1;
            cur_val_d   = din;
            rc_load     = 1'b1;
            state_d     = ST_ACQUIRE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    locked_d = (state_d == ST_TRACK);
  end

  // Sticky error flag and saturating count; a violation outranks a clear.
  always_comb begin
    err_d     = err_q | viol;
    err_cnt_d = err_cnt_q;
    if (viol && err_cnt_q != ERR_CNT_MAX) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
    if (clr_req) begin
      err_d     = viol;
      err_cnt_d = viol ? ERR_CNT_W'(1) : '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_val_q   <= '0;
      locked_q    <= 1'b0;
      new_val_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_val_q   <= cur_val_d;
      locked_q    <= locked_d;
      new_val_q   <= new_val_d;
      err_pulse_q <= err_pulse_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign cur_val   = cur_val_q;
  assign new_val   = new_val_q;
  assign err_pulse = err_pulse_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_repeat_seq_checker.sv
// Testbench for repeat_seq_checker: directed streams plus randomized traffic,
// compared every cycle against a behavioural model of the checker rules.
module tb_repeat_seq_checker;

  localparam int WIDTH = 4;
  localparam int REP   = 5;
  localparam int MAXV  = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             err_clr = 1'b0;
  logic             locked;
  logic [WIDTH-1:0] cur_val;
  logic             new_val;
  logic             err_pulse;
  logic             err;
  logic [7:0]       err_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = nothing sampled yet, 1 = searching, 2 = locked.
  int m_phase = 0;
  int m_cur   = 0;
  int m_run   = 0;
  int m_err   = 0;
  int m_cnt   = 0;
  int m_nv    = 0;
  int m_ep    = 0;

  repeat_seq_checker #(
    .WIDTH (WIDTH),
    .REP   (REP),
    .MAXV  (MAXV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .locked    (locked),
    .cur_val   (cur_val),
    .new_val   (new_val),
    .err_pulse (err_pulse),
    .err       (err),
    .err_cnt   (err_cnt)
`ifdef CHK_CLR_EN
    ,
    .err_clr   (err_clr)
`endif
  );

  always #5 clk = ~clk;

  function automatic int succ(input int v);
    return (v == MAXV) ? 0 : ((v + 1) % (1 << WIDTH));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cur = 0; m_run = 0; m_err = 0; m_cnt = 0; m_nv = 0; m_ep = 0;
  endtask

  task automatic model_sample(input int e, input int d, input int clr);
    int bad;
    bad = 0;
    m_nv = 0;
    m_ep = 0;
    if (e != 0) begin
      if (m_phase == 0) begin
        m_phase = 1; m_cur = d; m_run = 1;
      end else if (m_phase == 1) begin
        if (d == m_cur) begin
        end else if (d == succ(m_cur)) begin
          m_phase = 2; m_cur = d; m_run = 1; m_nv = 1;
        end else begin
          m_cur = d;
        end
      end else begin
        if (d <= MAXV && d == m_cur && m_run < REP) m_run = m_run + 1;
        else if (d <= MAXV && d == succ(m_cur) && m_run == REP) begin
          m_cur = d; m_run = 1; m_nv = 1;
        end else bad = 1;
      end
    end
    if (bad != 0) begin
      m_ep = 1; m_err = 1; m_phase = 1; m_cur = d; m_run = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
    if (clr != 0) begin
      m_err = bad;
      m_cnt = bad;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".locked"},    32'(locked),    (m_phase == 2) ? 32'd1 : 32'd0);
    chk({tag, ".cur_val"},   32'(cur_val),   32'(m_cur));
    chk({tag, ".new_val"},   32'(new_val),   32'(m_nv));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_ep));
    chk({tag, ".err"},       32'(err),       32'(m_err));
    chk({tag, ".err_cnt"},   32'(err_cnt),   32'(m_cnt));
    chk({tag, ".excl"},      32'(new_val & err_pulse), 32'd0);
  endtask

  // One clock: drive inputs, let the DUT sample, advance the model, compare.
  task automatic step(input string tag, input int e, input int d);
    int clr;
`ifdef CHK_CLR_EN
    clr = int'(err_clr);
`else
    clr = 0;
`endif
    en  = (e != 0);
    din = WIDTH'(d);
    @(posedge clk);
    model_sample(e, d, clr);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    en = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    chk_all(tag);
    rst = 1'b0;
  endtask

  task automatic run(input string tag, input int v, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, v);
  endtask

  initial begin
    int gv;
    int gc;
    int r;
    int pat[8];
    pat = '{0, 1, 3, 4, 6, 7, 9, 10};

    // Reset state, including reset with garbage inputs present.
    din = 4'hF;
    do_reset("reset");

    // Clean stream: 0..11 each REP times, wrap, then 0 and 1 again.
    for (int v = 0; v <= MAXV; v++) run("clean", v, REP);
    run("clean_wrap0", 0, REP);
    run("clean_wrap1", 1, REP);

    // Run too short: 2x5, 3x4, then 4; relock at 4->5.
    run("short", 2, REP);
    run("short", 3, REP - 1);
    run("short_viol", 4, REP);
    run("short_relock", 5, REP);

    // Run too long: 6 sampled six times, relock at 7.
    run("long", 6, REP + 1);
    run("long_relock", 7, REP);

    // Wrap legal vs out-of-range successor.
    do_reset("reset2");
    run("wrap", 10, REP);
    run("wrap", 11, REP);
    run("wrap_ok", 0, REP);
    do_reset("reset3");
    run("oor", 10, REP);
    run("oor", 11, REP);
    step("oor_viol", 1, 12);
    step("oor_after", 1, 13);

    // Gapped stream: garbage on din while en=0 must be ignored.
    do_reset("reset4");
    for (int v = 0; v <= MAXV; v++) begin
      for (int k = 0; k < REP; k++) begin
        step("gap_on", 1, v);
        step("gap_off", 0, $urandom_range(0, 15));
      end
    end

    // Reset in the middle of tracking.
    run("pre_rst", 0, 3);
    do_reset("mid_rst");
    run("post_rst", 4, 2);

    // Randomized traffic around a legal stream.
    do_reset("reset5");
    gv = $urandom_range(0, MAXV);
    gc = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset("rnd_rst");
      end else if (r < 15) begin
        step("rnd_gap", 0, $urandom_range(0, 15));
      end else if (r < 20) begin
        step("rnd_bad", 1, $urandom_range(0, 15));
      end else begin
        step("rnd_legal", 1, gv);
        gc++;
        if (gc >= REP) begin
          gc = 0;
          gv = succ(gv);
        end
      end
    end

    // Error counter saturation: one violation every two samples.
    do_reset("reset6");
    for (int i = 0; i < 560; i++) step("sat", 1, pat[i % 8]);
    chk("sat_final", 32'(err_cnt), 32'd255);

`ifdef CHK_CLR_EN
    // Clear after three errors, then a clear coinciding with a violation.
    do_reset("reset7");
    for (int i = 0; i < 7; i++) step("clr_pre", 1, pat[i]);
    step("clr_lock", 1, 10);
    err_clr = 1'b1;
    step("clr", 1, 10);
    err_clr = 1'b0;
    step("clr_after", 1, 10);
    err_clr = 1'b1;
    step("clr_viol", 1, 3);
    err_clr = 1'b0;
    step("clr_end", 1, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
